// File: rtl/layer_priority_arbiter.sv
// layer_priority_arbiter
// Programmable-priority pixel arbiter for the VGA object layers. A shadow
// rank/enable table is written through a valid/ready port and copied to the
// active table at frame start. Arbitration is a two-stage pipeline:
// stage 1 qualifies each layer, and stage 2 picks the lowest rank, with ties
// going to the lower index. A once-per-frame collision pulse is raised when
// layer 0 overlaps any other drawing layer.
//
// Handshake: a config write transfers on a rising clk edge where
// cfgValid && cfgReady. cfgReady is low during reset and in any cycle with
// startOfFrame=1. The master must hold cfgLayer/cfgRank/cfgEnable stable
// while cfgValid is high and cfgReady is low.
module layer_priority_arbiter #(
   parameter int          NUM_LAYERS  = 4,
   parameter logic [7:0]  TRANSPARENT = 8'hFF
) (
   input  logic                    clk,
   input  logic                    resetN,
   input  logic                    startOfFrame,
   input  logic [NUM_LAYERS-1:0]   drawReq,
   input  logic [8*NUM_LAYERS-1:0] layerRGB,
   input  logic [7:0]              backGroundRGB,
   input  logic                    cfgValid,
   output logic                    cfgReady,
   input  logic [2:0]              cfgLayer,
   input  logic [2:0]              cfgRank,
   input  logic                    cfgEnable,
   output logic [7:0]              RGBOut,
   output logic [2:0]              winnerId,
   output logic                    drawValid,
   output logic                    collision
);

   // Config tables: the shadow table is written by config, and the active table drives arbitration.
   logic [2:0]            r_shadow_rank [NUM_LAYERS];
   logic [NUM_LAYERS-1:0] r_shadow_en;
   logic [2:0]            r_active_rank [NUM_LAYERS];
   logic [NUM_LAYERS-1:0] r_active_en;

   // Stage-1 pipeline registers.
   logic [NUM_LAYERS-1:0] r_s1_v;
   logic [7:0]            r_s1_rgb  [NUM_LAYERS];
   logic [2:0]            r_s1_rank [NUM_LAYERS];
   logic [7:0]            r_s1_bg;

   // Collision re-arm flag.
   logic                  r_armed;

   // Combinational helpers.
   logic                  w_cfg_fire;
   logic [2:0]            w_eff_rank [NUM_LAYERS];
   logic [NUM_LAYERS-1:0] w_eff_en;
   logic [NUM_LAYERS-1:0] w_v;
   logic                  w_found;
   logic [2:0]            w_best_rank;
   logic [2:0]            w_best_idx;
   logic [7:0]            w_best_rgb;
   logic                  w_hit;

   // Writes are refused on the commit cycle so that the table copy never races a write.
   assign cfgReady   = resetN & ~startOfFrame;
   assign w_cfg_fire = cfgValid & cfgReady;

   // Shadow table update. Indices >= NUM_LAYERS match no entry, so the write is dropped.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         for (int i = 0; i < NUM_LAYERS; i++) begin
            r_shadow_rank[i] <= 3'(i);
         end
         r_shadow_en <= '1;
      end else if (w_cfg_fire) begin
         for (int i = 0; i < NUM_LAYERS; i++) begin
            if (cfgLayer == 3'(i)) begin
               r_shadow_rank[i] <= cfgRank;
               r_shadow_en[i]   <= cfgEnable;
            end
         end
      end
   end

   // Active table commit at frame start.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         for (int i = 0; i < NUM_LAYERS; i++) begin
            r_active_rank[i] <= 3'(i);
         end
         r_active_en <= '1;
      end else if (startOfFrame) begin
         for (int i = 0; i < NUM_LAYERS; i++) begin
            r_active_rank[i] <= r_shadow_rank[i];
         end
         r_active_en <= r_shadow_en;
      end
   end

   // The pixel sampled on the commit edge already uses the new table, so look through to shadow.
   always_comb begin
      w_eff_en = startOfFrame ? r_shadow_en : r_active_en;
      w_v      = '0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
         w_eff_rank[i] = startOfFrame ? r_shadow_rank[i] : r_active_rank[i];
         w_v[i]        = drawReq[i] & w_eff_en[i] & (layerRGB[8*i +: 8] != TRANSPARENT);
      end
   end

   // Stage 1: capture qualified requests, colours and the ranks in force for this pixel.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_s1_v  <= '0;
         r_s1_bg <= '0;
         for (int i = 0; i < NUM_LAYERS; i++) begin
            r_s1_rgb[i]  <= '0;
            r_s1_rank[i] <= '0;
         end
      end else begin
         r_s1_v  <= w_v;
         r_s1_bg <= backGroundRGB;
         for (int i = 0; i < NUM_LAYERS; i++) begin
            r_s1_rgb[i]  <= layerRGB[8*i +: 8];
            r_s1_rank[i] <= w_eff_rank[i];
         end
      end
   end

   // Winner search: strict less-than while scanning upward gives ties to the lower index.
   always_comb begin
      w_found     = 1'b0;
      w_best_rank = '0;
      w_best_idx  = '0;
      w_best_rgb  = '0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
         if (r_s1_v[i] && (!w_found || (r_s1_rank[i] < w_best_rank))) begin
            w_found     = 1'b1;
            w_best_rank = r_s1_rank[i];
            w_best_idx  = 3'(i);
            w_best_rgb  = r_s1_rgb[i];
         end
      end
   end

   assign w_hit = r_s1_v[0] & (|r_s1_v[NUM_LAYERS-1:1]);

   // Stage 2: registered outputs.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         RGBOut    <= '0;
         winnerId  <= '0;
         drawValid <= 1'b0;
         collision <= 1'b0;
      end else begin
         RGBOut    <= w_found ? w_best_rgb : r_s1_bg;
         winnerId  <= w_found ? w_best_idx : 3'd0;
         drawValid <= w_found;
         collision <= w_hit & r_armed;
      end
   end

   // Collision arm flag: frame start re-arms it, even when the same cycle fires a pulse.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_armed <= 1'b1;
      end else if (startOfFrame) begin
         r_armed <= 1'b1;
      end else if (w_hit && r_armed) begin
         r_armed <= 1'b0;
      end
   end

endmodule

// File: tb/tb_layer_priority_arbiter.sv
// tb_layer_priority_arbiter
// Directed bench for layer_priority_arbiter, with hand-computed expectations.
// Inputs are driven 1 ns after the rising edge. Outputs are sampled at the same point.
module tb_layer_priority_arbiter;

   localparam int NL = 4;

   logic          clk;
   logic          resetN;
   logic          startOfFrame;
   logic [NL-1:0] drawReq;
   logic [8*NL-1:0] layerRGB;
   logic [7:0]    backGroundRGB;
   logic          cfgValid;
   logic          cfgReady;
   logic [2:0]    cfgLayer;
   logic [2:0]    cfgRank;
   logic          cfgEnable;
   logic [7:0]    RGBOut;
   logic [2:0]    winnerId;
   logic          drawValid;
   logic          collision;

   int errors;
   int checks;

   layer_priority_arbiter #(.NUM_LAYERS(NL), .TRANSPARENT(8'hFF)) dut (
      .clk           (clk),
      .resetN        (resetN),
      .startOfFrame  (startOfFrame),
      .drawReq       (drawReq),
      .layerRGB      (layerRGB),
      .backGroundRGB (backGroundRGB),
      .cfgValid      (cfgValid),
      .cfgReady      (cfgReady),
      .cfgLayer      (cfgLayer),
      .cfgRank       (cfgRank),
      .cfgEnable     (cfgEnable),
      .RGBOut        (RGBOut),
      .winnerId      (winnerId),
      .drawValid     (drawValid),
      .collision     (collision)
   );

   // Clock and watchdog.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rgb(input int idx, input logic [7:0] val);
      layerRGB[8*idx +: 8] = val;
   endtask

   task automatic pulse_sof();
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
   endtask

   // Drive one config write and wait for acceptance (bounded).
   task automatic cfg_write(input logic [2:0] lyr, input logic [2:0] rnk, input logic en);
      bit done;
      done      = 1'b0;
      cfgValid  = 1'b1;
      cfgLayer  = lyr;
      cfgRank   = rnk;
      cfgEnable = en;
      #0;
      for (int k = 0; k < 10 && !done; k++) begin
         if (cfgReady) done = 1'b1;
         tick();
      end
      cfgValid = 1'b0;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL cfg_write_accept: layer %0d never accepted (got ready=%b, need 1)", lyr, cfgReady);
      end
   endtask

   task automatic test_reset();
      checks++; if (RGBOut !== 8'h00)   begin errors++; $display("FAIL reset_rgb: got %h need 00", RGBOut); end
      checks++; if (winnerId !== 3'd0)  begin errors++; $display("FAIL reset_winner: got %0d need 0", winnerId); end
      checks++; if (drawValid !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b need 0", drawValid); end
      checks++; if (collision !== 1'b0) begin errors++; $display("FAIL reset_coll: got %b need 0", collision); end
      checks++; if (cfgReady !== 1'b0)  begin errors++; $display("FAIL reset_ready: got %b need 0", cfgReady); end
      resetN = 1'b1;
      #1;
      checks++; if (cfgReady !== 1'b1)  begin errors++; $display("FAIL idle_ready: got %b need 1", cfgReady); end
      tick();
   endtask

   task automatic test_defaults();
      drawReq = 4'b0110;
      set_rgb(1, 8'h1C);
      set_rgb(2, 8'hE0);
      tick(); tick();
      checks++; if (RGBOut !== 8'h1C)   begin errors++; $display("FAIL def_rgb: got %h need 1C", RGBOut); end
      checks++; if (winnerId !== 3'd1)  begin errors++; $display("FAIL def_winner: got %0d need 1", winnerId); end
      checks++; if (drawValid !== 1'b1) begin errors++; $display("FAIL def_dv: got %b need 1", drawValid); end
      drawReq = 4'b0000;
      tick(); tick();
      checks++; if (RGBOut !== 8'h25)   begin errors++; $display("FAIL def_bg_rgb: got %h need 25", RGBOut); end
      checks++; if (drawValid !== 1'b0) begin errors++; $display("FAIL def_bg_dv: got %b need 0", drawValid); end
      checks++; if (winnerId !== 3'd0)  begin errors++; $display("FAIL def_bg_winner: got %0d need 0", winnerId); end
   endtask

   task automatic test_reprogram();
      drawReq = 4'b0110;
      cfg_write(3'd2, 3'd0, 1'b1);
      cfg_write(3'd1, 3'd2, 1'b1);
      tick(); tick();
      checks++; if (winnerId !== 3'd1) begin errors++; $display("FAIL reprog_before: got %0d need 1", winnerId); end
      pulse_sof();
      // Output at the commit edge still belongs to the previous pixel.
      checks++; if (winnerId !== 3'd1) begin errors++; $display("FAIL reprog_commit_edge: got %0d need 1", winnerId); end
      tick();
      checks++; if (winnerId !== 3'd2)  begin errors++; $display("FAIL reprog_winner: got %0d need 2", winnerId); end
      checks++; if (RGBOut !== 8'hE0)   begin errors++; $display("FAIL reprog_rgb: got %h need E0", RGBOut); end
   endtask

   task automatic test_transparency_enable();
      // Layer 0 requests but is transparent; layer 2 (rank 0) wins.
      drawReq = 4'b0111;
      set_rgb(0, 8'hFF);
      tick(); tick();
      checks++; if (winnerId !== 3'd2) begin errors++; $display("FAIL transp_winner: got %0d need 2", winnerId); end
      checks++; if (RGBOut !== 8'hE0)  begin errors++; $display("FAIL transp_rgb: got %h need E0", RGBOut); end
      drawReq = 4'b0000;
      cfg_write(3'd1, 3'd2, 1'b0);
      cfg_write(3'd3, 3'd0, 1'b1);
      pulse_sof();
      drawReq = 4'b1110;
      set_rgb(3, 8'h4A);
      tick(); tick();
      checks++; if (winnerId !== 3'd2) begin errors++; $display("FAIL tie_winner: got %0d need 2", winnerId); end
      drawReq = 4'b1010;
      tick(); tick();
      checks++; if (winnerId !== 3'd3) begin errors++; $display("FAIL dis_winner: got %0d need 3", winnerId); end
      checks++; if (RGBOut !== 8'h4A)  begin errors++; $display("FAIL dis_rgb: got %h need 4A", RGBOut); end
      drawReq = 4'b0010;
      tick(); tick();
      checks++; if (drawValid !== 1'b0) begin errors++; $display("FAIL dis_only_dv: got %b need 0", drawValid); end
      checks++; if (RGBOut !== 8'h25)   begin errors++; $display("FAIL dis_only_rgb: got %h need 25", RGBOut); end
      drawReq = 4'b0000;
   endtask

   task automatic test_collision();
      int pulses;
      int first;
      set_rgb(0, 8'h03);
      drawReq = 4'b0000;
      pulse_sof();
      tick();
      for (int pass = 0; pass < 2; pass++) begin
         pulses = 0;
         first  = -1;
         drawReq = 4'b1001;
         for (int c = 1; c <= 8; c++) begin
            if (c == 6) drawReq = 4'b0000;
            tick();
            if (collision === 1'b1) begin
               pulses++;
               if (first < 0) first = c;
            end
            if (c == 3) begin
               checks++;
               if (winnerId !== 3'd0 || RGBOut !== 8'h03) begin
                  errors++;
                  $display("FAIL coll_winner: got id %0d rgb %h need id 0 rgb 03", winnerId, RGBOut);
               end
            end
         end
         checks++; if (pulses != 1) begin errors++; $display("FAIL coll_count%0d: got %0d pulses need 1", pass, pulses); end
         checks++; if (first != 2)  begin errors++; $display("FAIL coll_latency%0d: got cycle %0d need 2", pass, first); end
         pulse_sof();
         tick();
      end
   endtask

   task automatic test_handshake();
      cfgValid  = 1'b1;
      cfgLayer  = 3'd1;
      cfgRank   = 3'd0;
      cfgEnable = 1'b1;
      startOfFrame = 1'b1;
      #1;
      checks++; if (cfgReady !== 1'b0) begin errors++; $display("FAIL hs_ready_sof: got %b need 0", cfgReady); end
      tick();
      startOfFrame = 1'b0;
      #1;
      checks++; if (cfgReady !== 1'b1) begin errors++; $display("FAIL hs_ready_after: got %b need 1", cfgReady); end
      tick();
      cfgValid = 1'b0;
      drawReq = 4'b0110;
      tick(); tick();
      checks++; if (winnerId !== 3'd2) begin errors++; $display("FAIL hs_not_yet: got %0d need 2", winnerId); end
      pulse_sof();
      tick();
      checks++; if (winnerId !== 3'd1) begin errors++; $display("FAIL hs_committed: got %0d need 1", winnerId); end
      checks++; if (RGBOut !== 8'h1C)  begin errors++; $display("FAIL hs_committed_rgb: got %h need 1C", RGBOut); end
      // Out-of-range layer index: accepted, no effect.
      cfg_write(3'd7, 3'd7, 1'b0);
      pulse_sof();
      drawReq = 4'b1000;
      tick(); tick();
      checks++; if (winnerId !== 3'd3 || drawValid !== 1'b1) begin
         errors++; $display("FAIL oob_layer3: got id %0d dv %b need id 3 dv 1", winnerId, drawValid);
      end
      drawReq = 4'b0001;
      tick(); tick();
      checks++; if (winnerId !== 3'd0 || drawValid !== 1'b1) begin
         errors++; $display("FAIL oob_layer0: got id %0d dv %b need id 0 dv 1", winnerId, drawValid);
      end
      drawReq = 4'b0000;
   endtask

   task automatic test_mid_reset();
      cfg_write(3'd0, 3'd0, 1'b0);
      pulse_sof();
      drawReq = 4'b0011;
      tick(); tick();
      checks++; if (winnerId !== 3'd1 || RGBOut !== 8'h1C) begin
         errors++; $display("FAIL prereset_winner: got id %0d rgb %h need id 1 rgb 1C", winnerId, RGBOut);
      end
      @(posedge clk);
      #3 resetN = 1'b0;
      #1;
      checks++; if (RGBOut !== 8'h00 || drawValid !== 1'b0 || winnerId !== 3'd0 || cfgReady !== 1'b0) begin
         errors++; $display("FAIL midreset_outputs: got rgb %h dv %b id %0d rdy %b need 00 0 0 0",
                            RGBOut, drawValid, winnerId, cfgReady);
      end
      @(posedge clk);
      #1 resetN = 1'b1;
      tick(); tick();
      checks++; if (winnerId !== 3'd0 || RGBOut !== 8'h03 || drawValid !== 1'b1) begin
         errors++; $display("FAIL postreset_default: got id %0d rgb %h dv %b need id 0 rgb 03 dv 1",
                            winnerId, RGBOut, drawValid);
      end
      checks++; if (collision !== 1'b1) begin errors++; $display("FAIL postreset_armed: got %b need 1", collision); end
      drawReq = 4'b0000;
      tick();
   endtask

   initial begin
      errors        = 0;
      checks        = 0;
      resetN        = 1'b0;
      startOfFrame  = 1'b0;
      drawReq       = '0;
      layerRGB      = '0;
      backGroundRGB = 8'h25;
      cfgValid      = 1'b0;
      cfgLayer      = '0;
      cfgRank       = '0;
      cfgEnable     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_defaults();
      test_reprogram();
      test_transparency_enable();
      test_collision();
      test_handshake();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/layer_priority_arbiter.md
# layer_priority_arbiter

Programmable-priority pixel arbiter for the VGA object layers: it replaces fixed-order layer selection with a per-layer rank/enable table and transparency masking. Each pixel clock it selects one RGB value from up to NUM_LAYERS object layers, or the background when no layer draws. It also reports a once-per-frame collision between layer 0 (player object) and any other drawing layer. It sits between the object drawing units and the VGA output stage; game logic reprograms priorities through a valid/ready config port, and new settings take effect only at frame start.

## Interface
- NUM_LAYERS, 4, number of object layers (2..8); layer index 0 is the collision reference layer.
- TRANSPARENT, 8'hFF, RGB value treated as "not drawing" even when the request is high.
- clk  in  1  pixel clock.
- resetN  in  1  asynchronous active-low reset.
- startOfFrame  in  1  one-cycle pulse at the first pixel of a frame; commits the config and re-arms collision.
- drawReq  in  NUM_LAYERS  per-layer drawing request.
- layerRGB  in  8*NUM_LAYERS  per-layer RGB; layer i occupies bits [8i+7:8i].
- backGroundRGB  in  8  colour used when no layer wins.
- cfgValid  in  1  config write request.
- cfgReady  out  1  config write accepted when cfgValid && cfgReady.
- cfgLayer  in  3  target layer index; values >= NUM_LAYERS are accepted and ignored.
- cfgRank  in  3  new rank; lower rank means higher priority.
- cfgEnable  in  1  new enable bit for the layer.
- RGBOut  out  8  selected colour.
- winnerId  out  3  index of the winning layer; 0 when drawValid=0.
- drawValid  out  1  a layer, not the background, produced RGBOut.
- collision  out  1  one-cycle pulse on the first layer-0 overlap of a frame.

## Operation
- Two tables of NUM_LAYERS entries, each {rank[2:0], enable}: a shadow table written by config and an active table used for arbitration. Reset value for both: rank[i]=i, enable=1, which gives fixed priority with layer 0 first.
- Config: a write is accepted when cfgValid && cfgReady and updates shadow[cfgLayer] in the same edge. cfgReady=0 during reset and in any cycle where startOfFrame=1, and 1 otherwise.
- Commit: at the edge where startOfFrame=1, active <= shadow. A write in the same cycle is not accepted, so the master holds it until the next cycle.
- Stage 1 (registered):
  - v[i] = drawReq[i] && active.enable[i] && layerRGB[i] != TRANSPARENT.
  - Register v, layerRGB, backGroundRGB and the active ranks.
- Stage 2 (registered outputs):
  - The winner is the valid layer with the lowest rank. A rank tie goes to the lower index.
  - No valid layer gives RGBOut=backGroundRGB, winnerId=0, drawValid=0.
- Collision:
  - hit = stage-1 v[0] && |v[NUM_LAYERS-1:1].
  - The armed flag sets on startOfFrame.
  - On a hit while armed, collision pulses high for 1 cycle, aligned with stage 2, and armed clears.
  - Further hits in the same frame produce no pulse.
  - A hit in the same cycle as startOfFrame: the pulse is issued if armed was set before the edge, and armed is set again by the frame start.
  - Armed reset value is 1.
- Disabled or transparent layers never win and never collide.

## Timing
- Latency is 2 cycles, input to RGBOut/winnerId/drawValid/collision, with throughput of 1 pixel per cycle. There is no stall; every cycle produces an output.
- Reset values: RGBOut=0, winnerId=0, drawValid=0, collision=0, cfgReady=0, pipeline valid bits 0.
- Reset is asynchronous and may arrive mid-frame or mid-write. It restores the default tables and clears the pipeline; any write pending at that moment is lost.
- Table switch: pixels sampled by stage 1 at or after the commit edge use the new active table. Pixels already in stage 1 keep the ranks they captured.
- Back-to-back config writes are allowed on every cycle with cfgReady=1. Shadow changes are invisible to arbitration until the next startOfFrame.

## Test plan
- Reset defaults:
  - Stimulus: drawReq=4'b0110, layerRGB1=8'h1C, layerRGB2=8'hE0.
  - Response: 2 cycles later RGBOut=8'h1C, winnerId=1, drawValid=1.
  - Stimulus: drawReq=0.
  - Response: RGBOut=backGroundRGB, drawValid=0.
- Reprogram priority:
  - Stimulus: write layer2 rank 0, layer1 rank 2, and hold the pixel inputs.
  - Response: output is unchanged until startOfFrame, then RGBOut=8'hE0, winnerId=2 for pixels entering after the commit edge.
- Transparency and enable:
  - Stimulus: layer0 requests with RGB 8'hFF.
  - Response: layer0 is ignored.
  - Stimulus: disable layer1 and commit.
  - Response: layer1 never wins; a rank tie between layers 2 and 3 selects 2.
- Collision:
  - Stimulus: layer0 and layer3 overlap for 5 consecutive pixels.
  - Response: exactly one collision pulse, 2 cycles after the first overlap.
  - Stimulus: startOfFrame, then overlap again.
  - Response: a second single pulse.
- Handshake corner:
  - Stimulus: cfgValid held high across a startOfFrame cycle.
  - Response: cfgReady=0 in that cycle, the write is accepted the next cycle, and the active table changes only at the following frame.
  - Stimulus: cfgLayer=7 with NUM_LAYERS=4.
  - Response: the write is accepted and has no effect.
- Mid-frame reset:
  - Stimulus: assert resetN=0 while programmed priorities are active.
  - Response: outputs are 0 immediately, and after release the default fixed priority holds.
